// File: rtl/pcs_serdes_pkg.sv
// Shared types, widths and the 64-bit serial scrambler used by the PCS TX gearbox.
package pcs_serdes_pkg;

  localparam int unsigned BLK_W = 66;
  localparam int unsigned OUT_W = 320;
  localparam int unsigned SCR_W = 58;
  localparam int unsigned PAY_W = BLK_W - 2;
  // Accumulator holds at most 319 residue bits plus one 66-bit block.
  localparam int unsigned ACC_W = OUT_W + BLK_W;
  localparam int unsigned CNT_W = 9;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [SCR_W-1:0] SCR_SEED_DFLT = 58'h3FF_FFFF_FFFF_FFFF;

  typedef logic [BLK_W-1:0] pcs_blk_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t BLK_BITS = cnt_t'(BLK_W);
  localparam cnt_t OUT_BITS = cnt_t'(OUT_W);

  typedef struct packed {
    logic [SCR_W-1:0] state;
    logic [PAY_W-1:0] payload;
  } scr_res_t;

  // Self-synchronous x^58+x^39+1 scrambler, bit 0 of payload first.
  function automatic scr_res_t scramble64(input logic [SCR_W-1:0] state,
                                          input logic [PAY_W-1:0] payload);
    scr_res_t         res;
    logic [SCR_W-1:0] s;
    logic             b;
    s           = state;
    res.payload = '0;
    for (int i = 0; i < int'(PAY_W); i++) begin
      b              = payload[i] ^ s[38] ^ s[57];
      res.payload[i] = b;
      s              = {s[SCR_W-2:0], b};
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/pcs_tx_serdes_gearbox_if.sv
// Block input and SerDes word output bundle of the PCS TX gearbox.
interface pcs_tx_serdes_gearbox_if;
  import pcs_serdes_pkg::*;

  pcs_blk_t         blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             scr_bypass;
  logic [OUT_W-1:0] sig_data;
  logic             sig_valid;
  logic [15:0]      hdr_err_cnt;

  // Upstream source plus SerDes sink side.
  modport master (
    output blk_data, blk_valid, scr_bypass,
    input  blk_ready, sig_data, sig_valid, hdr_err_cnt
  );

  // Gearbox side.
  modport slave (
    input  blk_data, blk_valid, scr_bypass,
    output blk_ready, sig_data, sig_valid, hdr_err_cnt
  );

endinterface

// File: rtl/pcs_tx_scrambler_64b66b.sv
// Stage 1: payload scrambling, sync-header check and header error counter.
module pcs_tx_scrambler_64b66b
  import pcs_serdes_pkg::*;
#(
  parameter logic [SCR_W-1:0] SCR_SEED = SCR_SEED_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  pcs_blk_t    blk_data_i,
  input  logic        blk_acc_i,
  input  logic        bypass_i,
  output pcs_blk_t    s1_blk_o,
  output logic        s1_vld_o,
  output logic [15:0] hdr_err_cnt_o
);

  logic [SCR_W-1:0] scr_q, scr_d;
  pcs_blk_t         s1_blk_q, s1_blk_d;
  logic             s1_vld_q;
  logic [15:0]      err_q, err_d;
  scr_res_t         scr_res;
  logic [1:0]       hdr;
  logic             hdr_bad;

  // Scramble the payload, keep the header clear, advance state only on accept.
  always_comb begin
    hdr      = blk_data_i[1:0];
    hdr_bad  = (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
    scr_res  = scramble64(scr_q, blk_data_i[BLK_W-1:2]);
    scr_d    = scr_q;
    s1_blk_d = s1_blk_q;
    err_d    = err_q;
    if (blk_acc_i) begin
      scr_d    = scr_res.state;
      s1_blk_d = {bypass_i ? blk_data_i[BLK_W-1:2] : scr_res.payload, hdr};
      if (hdr_bad && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'd1;
      end
    end
  end

  // Stage 1 registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scr_q    <= SCR_SEED;
      s1_blk_q <= '0;
      s1_vld_q <= 1'b0;
      err_q    <= '0;
    end else begin
      scr_q    <= scr_d;
      s1_blk_q <= s1_blk_d;
      s1_vld_q <= blk_acc_i;
      err_q    <= err_d;
    end
  end

  assign s1_blk_o      = s1_blk_q;
  assign s1_vld_o      = s1_vld_q;
  assign hdr_err_cnt_o = err_q;

endmodule

// File: rtl/pcs_tx_serdes_gearbox.sv
// PCS TX stage: scrambles 64b/66b blocks and packs them LSB-first into 320-bit SerDes words.
module pcs_tx_serdes_gearbox
  import pcs_serdes_pkg::*;
#(
  parameter logic [SCR_W-1:0] SCR_SEED = SCR_SEED_DFLT
) (
  input logic                    clk,
  input logic                    reset,
  pcs_tx_serdes_gearbox_if.slave bus_io
);

  logic             acc;
  pcs_blk_t         s1_blk;
  logic             s1_vld;
  logic [15:0]      err_cnt;

  logic [ACC_W-1:0] buf_q, buf_d, comb;
  cnt_t             cnt_q, cnt_d, ncnt;
  logic [OUT_W-1:0] word_q, word_d;
  logic             vld_q, vld_d;

  // The buffer can never overflow, so the only backpressure is reset itself.
  assign bus_io.blk_ready = ~reset;
  assign acc              = bus_io.blk_valid & bus_io.blk_ready;

  pcs_tx_scrambler_64b66b #(
    .SCR_SEED (SCR_SEED)
  ) u_scr (
    .clk           (clk),
    .reset         (reset),
    .blk_data_i    (bus_io.blk_data),
    .blk_acc_i     (acc),
    .bypass_i      (bus_io.scr_bypass),
    .s1_blk_o      (s1_blk),
    .s1_vld_o      (s1_vld),
    .hdr_err_cnt_o (err_cnt)
  );

  // Append the stage-1 block above the residue; emit a word once 320 bits are present.
  always_comb begin
    comb   = buf_q;
    ncnt   = cnt_q;
    if (s1_vld) begin
      comb = buf_q | ({{(ACC_W - BLK_W){1'b0}}, s1_blk} << cnt_q);
      ncnt = cnt_q + BLK_BITS;
    end
    word_d = word_q;
    buf_d  = comb;
    cnt_d  = ncnt;
    vld_d  = 1'b0;
    if (ncnt >= OUT_BITS) begin
      word_d = comb[OUT_W-1:0];
      buf_d  = comb >> OUT_W;
      cnt_d  = ncnt - OUT_BITS;
      vld_d  = 1'b1;
    end
  end

  // Accumulator and output word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign bus_io.sig_data    = word_q;
  assign bus_io.sig_valid   = vld_q;
  assign bus_io.hdr_err_cnt = err_cnt;

endmodule

// File: tb/tb_pcs_tx_serdes_gearbox.sv
// Self-checking bench: randomized blocks against a bit-stream model of scrambler and gearbox.
module tb_pcs_tx_serdes_gearbox;
  import pcs_serdes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pcs_tx_serdes_gearbox_if bus ();

  pcs_tx_serdes_gearbox dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           hist[$];    // last 58 transmitted scrambler bits, oldest first
  bit           mq[$];      // serial output bits not yet in a word
  bit           known = 0;
  logic         ev0 = 0, ev1 = 0;
  logic [319:0] ew0 = '0, ew1 = '0;
  logic [319:0] last_word = '0;
  logic [15:0]  exp_err = '0;
  int           pulses = 0;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    mq.delete();
    ev0 = 0; ev1 = 0; last_word = '0; exp_err = '0;
  endtask

  task automatic model_accept(input logic [65:0] blk, input logic byp);
    logic [65:0]  o;
    logic [319:0] w;
    bit           s;
    o[1:0] = blk[1:0];
    for (int i = 0; i < 64; i++) begin
      // s(n) = d(n) ^ s(n-39) ^ s(n-58)
      s = blk[i+2] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(s);
      void'(hist.pop_front());
      o[i+2] = byp ? blk[i+2] : s;
    end
    for (int i = 0; i < 66; i++) mq.push_back(o[i]);
    if ((blk[1:0] == 2'b00 || blk[1:0] == 2'b11) && exp_err != 16'hFFFF) exp_err++;
    if (mq.size() >= 320) begin
      for (int i = 0; i < 320; i++) w[i] = mq.pop_front();
      ev1 = 1; ew1 = w;
    end
  endtask

  // Compare process: every cycle once the DUT has seen a reset.
  always @(negedge clk) begin
    if (known) begin
      chk("blk_ready", 320'(bus.blk_ready), 320'(!reset));
      chk("sig_valid", 320'(bus.sig_valid), 320'(ev0));
      if (ev0) last_word = ew0;
      chk("sig_data", bus.sig_data, last_word);
      chk("hdr_err_cnt", 320'(bus.hdr_err_cnt), 320'(exp_err));
    end
    if (bus.sig_valid === 1'b1) pulses++;
    if (reset) begin
      model_reset();
      known = 1;
    end else begin
      ev0 = ev1; ew0 = ew1; ev1 = 0;
      if (bus.blk_valid) model_accept(bus.blk_data, bus.scr_bypass);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.blk_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  logic [65:0]  b[5];
  logic [319:0] w_exp;
  logic [65:0]  slot0_exp;
  int           n_acc;

  initial begin
    bus.blk_data   = '0;
    bus.blk_valid  = 1'b0;
    bus.scr_bypass = 1'b0;

    // 1: reset held with blk_valid high
    reset = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = {64'h1234, 2'b01};
    step(); step();
    @(negedge clk);
    chk("t1_ready_in_reset", 320'(bus.blk_ready), 320'(0));
    chk("t1_valid_in_reset", 320'(bus.sig_valid), 320'(0));
    chk("t1_data_in_reset", bus.sig_data, 320'(0));
    step();
    reset = 1'b0;
    bus.blk_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", 320'(bus.blk_ready), 320'(1));
    step();

    // 2: five bypassed blocks back-to-back
    do_reset(2);
    bus.scr_bypass = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b[i] = {64'(i), 2'b01};
      bus.blk_data  = b[i];
      bus.blk_valid = 1'b1;
      step();
    end
    bus.blk_valid = 1'b0;
    @(negedge clk);
    chk("t2_no_word_cycle5", 320'(bus.sig_valid), 320'(0));
    step();
    @(negedge clk);
    w_exp = {b[4][55:0], b[3], b[2], b[1], b[0]};
    chk("t2_valid_cycle6", 320'(bus.sig_valid), 320'(1));
    chk("t2_word", bus.sig_data, w_exp);
    #1;
    chk("t2_model_residue", 320'(mq.size()), 320'(10));
    step();

    // 3: 160 bypassed blocks fill exactly 33 words
    do_reset(1);
    pulses = 0;
    for (int i = 0; i < 160; i++) begin
      bus.blk_data  = {rnd64(), 2'b01};
      bus.blk_valid = 1'b1;
      step();
    end
    bus.blk_valid = 1'b0;
    repeat (4) step();
    chk("t3_pulses", 320'(pulses), 320'(33));
    chk("t3_model_residue", 320'(mq.size()), 320'(0));

    // 4: scrambled all-zero payload from the all-ones seed
    do_reset(1);
    bus.scr_bypass = 1'b0;
    pulses = 0;
    slot0_exp = {64'h03FF_FF80_0000_0000, 2'b10};
    for (int i = 0; i < 160; i++) begin
      bus.blk_data  = {64'h0, 2'b10};
      bus.blk_valid = 1'b1;
      if (i == 6) begin
        @(negedge clk);
        w_exp = bus.sig_data;
        chk("t4_slot0", 320'(w_exp[65:0]), 320'(slot0_exp));
        chk("t4_slot1_hdr", 320'(w_exp[67:66]), 320'(2'b10));
      end
      step();
    end
    bus.blk_valid = 1'b0;
    repeat (4) step();
    chk("t4_pulses", 320'(pulses), 320'(33));

    // 5: 50% random gaps, random headers and bypass toggling
    do_reset(1);
    pulses = 0;
    n_acc  = 0;
    while (n_acc < 1000) begin
      bus.blk_valid  = 1'($urandom_range(0, 1));
      bus.blk_data   = {rnd64(), 2'($urandom_range(0, 3))};
      bus.scr_bypass = 1'($urandom_range(0, 1));
      if (bus.blk_valid) n_acc++;
      step();
    end
    bus.blk_valid  = 1'b0;
    bus.scr_bypass = 1'b0;
    repeat (4) step();
    chk("t5_pulses", 320'(pulses), 320'(206));
    chk("t5_model_residue", 320'(mq.size()), 320'(80));

    // 6: reset after three blocks, then five fresh blocks
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      bus.blk_data  = {rnd64(), 2'b01};
      bus.blk_valid = 1'b1;
      step();
    end
    pulses = 0;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      bus.blk_data  = {rnd64(), 2'b10};
      bus.blk_valid = 1'b1;
      step();
    end
    bus.blk_valid = 1'b0;
    repeat (4) step();
    chk("t6_pulses", 320'(pulses), 320'(1));

    // 7: header-error counter saturation over 70000 bad blocks
    do_reset(1);
    pulses = 0;
    for (int i = 0; i < 70000; i++) begin
      bus.blk_data  = {rnd64(), 2'b11};
      bus.blk_valid = 1'b1;
      step();
    end
    bus.blk_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t7_err_saturated", 320'(bus.hdr_err_cnt), 320'(16'hFFFF));
    chk("t7_pulses", 320'(pulses), 320'(14437));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
